bp_me_burst_to_stream_gearbox: RTL and testbench
================================================

BP_ME_BURST_TO_STREAM_GEARBOX -- requirements
Module: bp_me_burst_to_stream_gearbox

Interface
REQ-001 SHALL have parameter bp_params_p, default e_bp_default_cfg, processor config supplying paddr_width_p, lce_id_width_p, lce_assoc_p.
REQ-002 SHALL have parameter in_data_width_p, default "inv", burst data width; power of 2, >= out_data_width_p.
REQ-003 SHALL have parameter out_data_width_p, default in_data_width_p, stream data width; power of 2, >= 64; ratio R = in/out.
REQ-004 SHALL have parameter block_width_p, default "inv", cache block width; block_width_p >= in_data_width_p; W = block_width_p/out_data_width_p stream words per block.
REQ-005 SHALL have parameter payload_width_p, default "inv", bedrock payload width.
REQ-006 SHALL have parameter payload_mask_p, default 0, bit per msg_type; 1 = message carries data.
REQ-007 SHALL use clk_i, input, 1, sole clock; reset_i, input, 1, synchronous active-high reset.
REQ-008 SHALL have in_msg_header_i/in_msg_header_v_i/in_msg_header_ready_and_o, bedrock burst header in (in widths), ready-valid-and.
REQ-009 SHALL have in_msg_data_i (in_data_width_p)/in_msg_data_v_i/in_msg_data_ready_and_o, burst data in, ready-valid-and.
REQ-010 SHALL have out_msg_header_o (out header width), out_msg_data_o (out_data_width_p), out_msg_v_o, out_msg_ready_and_i, out_msg_last_o, bedrock stream out, ready-valid-and.

Function
REQ-011 SHALL implement states IDLE and STREAM; IDLE->STREAM on header handshake; STREAM->IDLE on out handshake with out_msg_last_o=1.
REQ-012 SHALL assert in_msg_header_ready_and_o only in IDLE; header registered on handshake, no combinational header bypass (min 1 cycle header-to-out latency).
REQ-013 SHALL compute beat count N = max((1<<size)/(out_data_width_p/8), 1) for has_data messages, N = 1 otherwise.
REQ-014 SHALL hold one burst word in a R-slice buffer; in_msg_data_ready_and_o = STREAM & has_data & (buffer empty | (buffer's final slice handed off this cycle & more beats remain)).
REQ-015 SHALL drive stream beat k (0..N-1) from slice k mod R of burst word floor(k/R); burst words packed from the first (critical) stream word.
REQ-016 SHALL assert out_msg_v_o in STREAM when has_data=0, or when buffer holds a valid slice; out_msg_data_o = 0 when has_data=0.
REQ-017 SHALL drive out_msg_header_o = registered header with addr stream-word index field = first_idx + k, where first_idx = addr[log2(out/8) +: log2(W)]; low byte offset bits preserved.
REQ-018 SHALL assert out_msg_last_o = out_msg_v_o & (k == N-1).
REQ-019 SHALL release the buffer after the last beat even if fewer than R slices were consumed (N < R or N not multiple of R).
REQ-020 SHALL allow header handshake in the cycle after the final beat; no same-cycle overlap.
REQ-021 SHALL hold all outputs stable while out_msg_v_o=1 & out_msg_ready_and_i=0.

Reset
REQ-022 SHALL, with reset_i=1 at a clock edge, enter IDLE, clear beat counter and buffer valid, discarding any in-flight message.
REQ-023 SHALL drive out_msg_v_o=0, out_msg_last_o=0, in_msg_data_ready_and_o=0, in_msg_header_ready_and_o=0 while reset_i=1; header ready=1 first cycle after reset deasserts.

Configuration
REQ-024 SHALL honour macro BP_ME_B2S_WRAP_EN: defined -> index field = (first_idx + k) mod W, wrapping within block, upper addr bits unchanged; undefined -> addr increments linearly by k*(out_data_width_p/8), carrying into upper bits.

Verification
REQ-025 SHALL cover (in=128,out=64,block=512) write, size 64B, addr 0x1000, 4 burst words -> 8 beats, addrs 0x1000..0x1038 step 8, last on beat 8.
REQ-026 SHALL cover same with addr 0x1030 -> WRAP_EN: addrs 0x1030,0x1038,0x1000..0x1028; no WRAP_EN: 0x1030..0x1068.
REQ-027 SHALL cover no-data read, size 64B, addr 0x2000 -> single beat, last=1, in_msg_data_ready_and_o never asserted.
REQ-028 SHALL cover 8B write (N=1<R) -> 1 beat from slice 0, buffer freed, next header accepted cycle after last.
REQ-029 SHALL cover out_msg_ready_and_i toggling 1010... during 8-beat write -> data/addr order identical, outputs stable when stalled.
REQ-030 SHALL cover reset_i pulse after beat 3 of 8 -> out_msg_v_o=0 during reset, IDLE after, next message streams correctly from beat 0.

Source files
------------

// File: rtl/bp_me_burst_to_stream_gearbox.sv
// Burst-to-stream gearbox. It accepts one BedRock burst header and the burst data words
// that follow it. It then emits the message as a stream of out_data_width_p beats, and each
// beat carries a header whose address points at that beat's stream word.
//
// Header layout: {payload, addr[paddr_width_p], size[2:0], msg_type[3:0]}, LSB first.
// The size field encodes the byte count as (1 << size).
//
// Build option: define BP_ME_B2S_WRAP_EN to wrap the stream-word index of each beat address
// within the cache block. When it is undefined, the beat addresses increment linearly and
// carry into the upper bits.
module bp_me_burst_to_stream_gearbox #(
    parameter int unsigned bp_params_p      = 0,
    parameter int unsigned in_data_width_p  = 128,
    parameter int unsigned out_data_width_p = in_data_width_p,
    parameter int unsigned block_width_p    = 512,
    parameter int unsigned payload_width_p  = 16,
    parameter logic [15:0] payload_mask_p   = '0,
    localparam int unsigned paddr_width_p   = (bp_params_p == 0) ? 40 : 56,
    localparam int unsigned hdr_width_lp    = payload_width_p + paddr_width_p + 7
) (
    input  logic                        clk_i,
    input  logic                        reset_i,

    input  logic [hdr_width_lp-1:0]     in_msg_header_i,
    input  logic                        in_msg_header_v_i,
    output logic                        in_msg_header_ready_and_o,

    input  logic [in_data_width_p-1:0]  in_msg_data_i,
    input  logic                        in_msg_data_v_i,
    output logic                        in_msg_data_ready_and_o,

    output logic [hdr_width_lp-1:0]     out_msg_header_o,
    output logic [out_data_width_p-1:0] out_msg_data_o,
    output logic                        out_msg_v_o,
    input  logic                        out_msg_ready_and_i,
    output logic                        out_msg_last_o
);

    localparam int unsigned ratio_lp    = in_data_width_p / out_data_width_p;
    localparam int unsigned off_w_lp    = $clog2(out_data_width_p / 8);
    localparam int unsigned cnt_w_lp    = 8;
    localparam int unsigned slc_w_lp    = $clog2(ratio_lp + 1);
    localparam int unsigned size_lsb_lp = 4;
    localparam int unsigned addr_lsb_lp = 7;
`ifdef BP_ME_B2S_WRAP_EN
    localparam int unsigned words_lp    = block_width_p / out_data_width_p;
    localparam int unsigned idx_w_lp    = (words_lp > 1) ? $clog2(words_lp) : 1;
`endif

    typedef enum logic {StIdle, StStream} state_e;

    state_e                      r_state, w_state_next;
    logic [hdr_width_lp-1:0]     r_hdr;
    logic                        r_has_data;
    logic [cnt_w_lp-1:0]         r_n;
    logic [cnt_w_lp-1:0]         r_k;
    logic [in_data_width_p-1:0]  r_buf;
    logic [slc_w_lp-1:0]         r_buf_cnt;

    logic [3:0]                  w_in_type;
    logic [2:0]                  w_in_size;
    logic                        w_in_has_data;
    logic [7:0]                  w_in_bytes;
    logic [cnt_w_lp-1:0]         w_in_n;
    logic                        w_hdr_hs;
    logic                        w_data_hs;
    logic                        w_out_hs;
    logic                        w_last;
    logic [paddr_width_p-1:0]    w_addr;
    logic [paddr_width_p-1:0]    w_addr_k;

    // Decode the beat count of the incoming header; a message without data is one beat.
    always_comb begin
        w_in_type     = in_msg_header_i[3:0];
        w_in_size     = in_msg_header_i[size_lsb_lp +: 3];
        w_in_has_data = payload_mask_p[w_in_type];
        w_in_bytes    = 8'd1 << w_in_size;
        w_in_n        = w_in_bytes >> off_w_lp;
        if (!w_in_has_data || (w_in_n == '0)) begin
            w_in_n = cnt_w_lp'(1);
        end
    end

    // Next state and handshake outputs; reset forces every valid/ready low.
    always_comb begin
        w_state_next              = r_state;
        in_msg_header_ready_and_o = 1'b0;
        in_msg_data_ready_and_o   = 1'b0;
        out_msg_v_o               = 1'b0;
        out_msg_last_o            = 1'b0;
        w_last                    = (r_k == (r_n - cnt_w_lp'(1)));
        unique case (r_state)
            StIdle: begin
                in_msg_header_ready_and_o = ~reset_i;
                if (in_msg_header_v_i && !reset_i) begin
                    w_state_next = StStream;
                end
            end
            StStream: begin
                out_msg_v_o    = ~reset_i & (~r_has_data | (r_buf_cnt != '0));
                out_msg_last_o = out_msg_v_o & w_last;
                // Refill when empty, or when the last held slice leaves and more beats follow.
                in_msg_data_ready_and_o = ~reset_i & r_has_data
                    & ((r_buf_cnt == '0)
                       | (out_msg_v_o & out_msg_ready_and_i
                          & (r_buf_cnt == slc_w_lp'(1)) & ~w_last));
                if (out_msg_v_o && out_msg_ready_and_i && w_last) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign w_hdr_hs  = in_msg_header_v_i & in_msg_header_ready_and_o;
    assign w_data_hs = in_msg_data_v_i & in_msg_data_ready_and_o;
    assign w_out_hs  = out_msg_v_o & out_msg_ready_and_i;

    // Per-beat header address and data slice.
    always_comb begin
        w_addr = r_hdr[addr_lsb_lp +: paddr_width_p];
`ifdef BP_ME_B2S_WRAP_EN
        w_addr_k = w_addr;
        w_addr_k[off_w_lp +: idx_w_lp] = w_addr[off_w_lp +: idx_w_lp] + r_k[idx_w_lp-1:0];
`else
        w_addr_k = w_addr + (paddr_width_p'(r_k) << off_w_lp);
`endif
        out_msg_header_o = r_hdr;
        out_msg_header_o[addr_lsb_lp +: paddr_width_p] = w_addr_k;
        out_msg_data_o = r_has_data ? r_buf[out_data_width_p-1:0] : '0;
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Capture the header on acceptance and count beats as they leave.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_k <= '0;
        end else if (w_hdr_hs) begin
            r_hdr      <= in_msg_header_i;
            r_has_data <= w_in_has_data;
            r_n        <= w_in_n;
            r_k        <= '0;
        end else if (w_out_hs) begin
            r_k <= w_last ? '0 : r_k + cnt_w_lp'(1);
        end
    end

    // Burst word buffer: slice 0 is always the current beat, the rest shift down behind it.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_buf_cnt <= '0;
        end else if (w_data_hs) begin
            r_buf     <= in_msg_data_i;
            r_buf_cnt <= slc_w_lp'(ratio_lp);
        end else if (w_out_hs && r_has_data) begin
            if (w_last) begin
                r_buf_cnt <= '0;
            end else begin
                r_buf     <= r_buf >> out_data_width_p;
                r_buf_cnt <= r_buf_cnt - slc_w_lp'(1);
            end
        end
    end

endmodule

// File: tb/tb_bp_me_burst_to_stream_gearbox.sv
// Self-checking bench for bp_me_burst_to_stream_gearbox (in=128, out=64, block=512).
// The bench expands each message into its expected beats from the address/size rules and
// checks every accepted output beat against that list. It also follows
// BP_ME_B2S_WRAP_EN when computing expected addresses.
module tb_bp_me_burst_to_stream_gearbox;

    localparam int          HW   = 63;
    localparam logic [15:0] MASK = 16'h000A;  // msg types 1 and 3 carry data

    typedef struct {
        logic [HW-1:0] hdr;
        logic [63:0]   data;
        logic          last;
    } beat_t;

    logic          clk;
    logic          reset;
    logic [HW-1:0] hdr_i;
    logic          hdr_v;
    logic          hready;
    logic [127:0]  data_i;
    logic          data_v;
    logic          dready;
    logic [HW-1:0] out_hdr;
    logic [63:0]   out_data;
    logic          out_v;
    logic          out_ready;
    logic          out_last;

    beat_t         exp_q[$];
    logic [39:0]   obs_addr[$];
    logic          obs_last[$];
    logic [39:0]   exp26[8];
    int            n_checks = 0;
    int            n_errors = 0;
    int            ready_mode = 0;

    bp_me_burst_to_stream_gearbox #(
        .bp_params_p      (0),
        .in_data_width_p  (128),
        .out_data_width_p (64),
        .block_width_p    (512),
        .payload_width_p  (16),
        .payload_mask_p   (MASK)
    ) dut (
        .clk_i                     (clk),
        .reset_i                   (reset),
        .in_msg_header_i           (hdr_i),
        .in_msg_header_v_i         (hdr_v),
        .in_msg_header_ready_and_o (hready),
        .in_msg_data_i             (data_i),
        .in_msg_data_v_i           (data_v),
        .in_msg_data_ready_and_o   (dready),
        .out_msg_header_o          (out_hdr),
        .out_msg_data_o            (out_data),
        .out_msg_v_o               (out_v),
        .out_msg_ready_and_i       (out_ready),
        .out_msg_last_o            (out_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int nbeats(input logic [HW-1:0] h);
        int n;
        if (!MASK[h[3:0]]) return 1;
        n = (1 << h[6:4]) / 8;
        return (n == 0) ? 1 : n;
    endfunction

    // Expand one message into its expected stream beats.
    function automatic void model_push(input logic [HW-1:0] h, input logic [127:0] w[$]);
        logic [39:0]  a;
        logic [127:0] wd;
        int           n;
        beat_t        b;
        a = h[46:7];
        n = nbeats(h);
        for (int k = 0; k < n; k++) begin
            b.hdr = h;
`ifdef BP_ME_B2S_WRAP_EN
            b.hdr[46:7] = {a[39:6], 6'(a[5:0] + 6'(k * 8))};
`else
            b.hdr[46:7] = a + 40'(k * 8);
`endif
            if (MASK[h[3:0]]) begin
                wd     = w[k / 2];
                b.data = 64'(wd >> ((k % 2) * 64));
            end else begin
                b.data = 64'h0;
            end
            b.last = (k == n - 1);
            exp_q.push_back(b);
        end
    endfunction

    task automatic drive_hdr(input logic [HW-1:0] h);
        logic done;
        done  = 1'b0;
        hdr_i = h;
        hdr_v = 1'b1;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            done = hready;
            @(posedge clk);
            #1;
        end
        hdr_v = 1'b0;
        chk("hdr_accept", 64'(done), 64'd1);
    endtask

    task automatic drive_word(input logic [127:0] w);
        logic done;
        done   = 1'b0;
        data_i = w;
        data_v = 1'b1;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            done = dready;
            @(posedge clk);
            #1;
        end
        data_v = 1'b0;
        chk("data_accept", 64'(done), 64'd1);
    endtask

    task automatic send_msg(input logic [3:0] t, input logic [2:0] sz, input logic [39:0] a);
        logic [HW-1:0] h;
        logic [127:0]  w[$];
        int            nw;
        h  = {16'($urandom), a, sz, t};
        nw = MASK[t] ? (nbeats(h) + 1) / 2 : 0;
        for (int i = 0; i < nw; i++) w.push_back({$urandom, $urandom, $urandom, $urandom});
        model_push(h, w);
        drive_hdr(h);
        for (int i = 0; i < nw; i++) drive_word(w[i]);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 400 && exp_q.size() != 0; t++) @(negedge clk);
        chk("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_out_v", 64'(out_v), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_data_ready", 64'(dready), 64'd0);
        chk("rst_hdr_ready", 64'(hready), 64'd0);
    endtask

    // Output ready pattern: 0 always ready, 1 random, 2 alternating.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = ~out_ready;
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Compare every accepted beat to the model; check stall stability and post-last readiness.
    initial begin
        beat_t         e;
        logic [HW-1:0] p_hdr;
        logic [63:0]   p_data;
        logic          p_last;
        logic          p_stall;
        logic          p_lasths;
        p_stall  = 1'b0;
        p_lasths = 1'b0;
        p_hdr    = '0;
        p_data   = '0;
        p_last   = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                p_stall  = 1'b0;
                p_lasths = 1'b0;
            end else begin
                if (p_lasths) chk("hdr_ready_after_last", 64'(hready), 64'd1);
                if (p_stall) begin
                    chk("stall_v", 64'(out_v), 64'd1);
                    chk("stall_hdr", 64'(out_hdr), 64'(p_hdr));
                    chk("stall_data", out_data, p_data);
                    chk("stall_last", 64'(out_last), 64'(p_last));
                end
                if (out_v && exp_q.size() > 0 && !MASK[exp_q[0].hdr[3:0]]) begin
                    chk("nodata_data_ready", 64'(dready), 64'd0);
                end
                p_lasths = 1'b0;
                if (out_v && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_beat", 64'(exp_q.size()), 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_hdr", 64'(out_hdr), 64'(e.hdr));
                        chk("beat_data", out_data, e.data);
                        chk("beat_last", 64'(out_last), 64'(e.last));
                    end
                    obs_addr.push_back(out_hdr[46:7]);
                    obs_last.push_back(out_last);
                    p_lasths = out_last;
                end
                p_stall = out_v && !out_ready;
                p_hdr   = out_hdr;
                p_data  = out_data;
                p_last  = out_last;
            end
        end
    end

    initial begin
        logic [HW-1:0] h;
        logic [127:0]  w[$];
        logic          done;
`ifdef BP_ME_B2S_WRAP_EN
        exp26 = '{40'h1030, 40'h1038, 40'h1000, 40'h1008,
                  40'h1010, 40'h1018, 40'h1020, 40'h1028};
`else
        exp26 = '{40'h1030, 40'h1038, 40'h1040, 40'h1048,
                  40'h1050, 40'h1058, 40'h1060, 40'h1068};
`endif
        reset  = 1'b1;
        hdr_v  = 1'b0;
        data_v = 1'b0;
        hdr_i  = '0;
        data_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("hdr_ready_after_reset", 64'(hready), 64'd1);
        @(posedge clk);
        #1;

        // 64B write at 0x1000: 8 beats, step 8, last on beat 8.
        obs_addr.delete();
        obs_last.delete();
        send_msg(4'd1, 3'd6, 40'h1000);
        wait_drain();
        chk("w64_beats", 64'(obs_addr.size()), 64'd8);
        for (int i = 0; i < obs_addr.size(); i++) begin
            chk("w64_addr", 64'(obs_addr[i]), 64'(40'h1000 + 40'(i * 8)));
            chk("w64_last", 64'(obs_last[i]), 64'(i == 7));
        end

        // 64B write starting mid-block at 0x1030.
        obs_addr.delete();
        obs_last.delete();
        send_msg(4'd1, 3'd6, 40'h1030);
        wait_drain();
        chk("w64_mid_beats", 64'(obs_addr.size()), 64'd8);
        for (int i = 0; i < obs_addr.size(); i++) begin
            chk("w64_mid_addr", 64'(obs_addr[i]), 64'(exp26[i]));
        end

        // No-data read: single beat, last set.
        obs_addr.delete();
        obs_last.delete();
        send_msg(4'd0, 3'd6, 40'h2000);
        wait_drain();
        chk("read_beats", 64'(obs_addr.size()), 64'd1);
        if (obs_addr.size() > 0) begin
            chk("read_addr", 64'(obs_addr[0]), 64'h2000);
            chk("read_last", 64'(obs_last[0]), 64'd1);
        end

        // 8B write (one beat from slice 0), then a header right behind it.
        obs_addr.delete();
        obs_last.delete();
        send_msg(4'd1, 3'd3, 40'h3008);
        send_msg(4'd0, 3'd0, 40'h4000);
        wait_drain();
        chk("w8_beats", 64'(obs_addr.size()), 64'd2);
        if (obs_addr.size() > 1) begin
            chk("w8_addr", 64'(obs_addr[0]), 64'h3008);
            chk("w8_last", 64'(obs_last[0]), 64'd1);
            chk("w8_next_addr", 64'(obs_addr[1]), 64'h4000);
        end

        // Alternating output ready during an 8-beat write.
        ready_mode = 2;
        obs_addr.delete();
        obs_last.delete();
        send_msg(4'd1, 3'd6, 40'h5000);
        wait_drain();
        ready_mode = 0;
        chk("toggle_beats", 64'(obs_addr.size()), 64'd8);

        // Reset after three of eight beats, then a clean message.
        @(posedge clk);
        #1;
        obs_addr.delete();
        obs_last.delete();
        h = {16'h00AA, 40'h6000, 3'd6, 4'd1};
        for (int i = 0; i < 4; i++) w.push_back({$urandom, $urandom, $urandom, $urandom});
        model_push(h, w);
        drive_hdr(h);
        drive_word(w[0]);
        drive_word(w[1]);
        done = 1'b0;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            #1;
            done = (obs_addr.size() >= 3);
        end
        chk("rst_mid_beats_before", 64'(obs_addr.size()), 64'd3);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_mid_out_v", 64'(out_v), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_hdr_ready", 64'(hready), 64'd1);
        @(posedge clk);
        #1;
        obs_addr.delete();
        obs_last.delete();
        send_msg(4'd3, 3'd6, 40'h7010);
        wait_drain();
        chk("post_rst_beats", 64'(obs_addr.size()), 64'd8);
        if (obs_addr.size() > 0) chk("post_rst_first_addr", 64'(obs_addr[0]), 64'h7010);

        // Randomized traffic.
        for (int m = 0; m < 60; m++) begin
            ready_mode = $urandom_range(0, 2);
            send_msg(4'($urandom_range(0, 3)), 3'($urandom_range(0, 6)),
                     {8'($urandom), $urandom});
        end
        ready_mode = 0;
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
